// File: rtl/mouse_pkg.sv
// rtl/mouse_pkg.sv - shared position type, debounce states and 1024x768 active-area defaults
package mouse_pkg;

  typedef logic [11:0] pos_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    DOWN,
    REL_WAIT
  } debounce_state_t;

  localparam int unsigned H_ACTIVE_DEF = 1024;
  localparam int unsigned V_ACTIVE_DEF = 768;

  // Saturate a raw coordinate to the last visible pixel/line instead of wrapping.
  function automatic pos_t clamp_pos(input pos_t raw, input int unsigned lim);
    return (raw >= pos_t'(lim)) ? pos_t'(lim - 1) : raw;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer plus counted debounce FSM giving a held level and press pulse
module btn_debounce
  import mouse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic held,
  output logic press_pulse,
  output logic press_fire
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            s;
  logic [CW-1:0]   cnt;
  debounce_state_t state;

  // Combinational view of the edge that will raise press_pulse, so the parent can capture
  // data in the same edge as the pulse is registered.
  assign press_fire = (state == PRESS_WAIT) && s && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      s           <= 1'b0;
      cnt         <= '0;
      state       <= IDLE;
      held        <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= raw;
      s           <= sync1;
      press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state       <= DOWN;
            cnt         <= '0;
            held        <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DOWN: begin
          if (!s) begin
            state <= REL_WAIT;
            cnt   <= CW'(1);
          end
        end
        REL_WAIT: begin
          if (s) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mouse_frame_latch.sv
// rtl/mouse_frame_latch.sv - clamps and frame-latches mouse position, debounces buttons; MOUSE_RIGHT_BTN_EN adds the right button
module mouse_frame_latch
  import mouse_pkg::*;
#(
  parameter int unsigned H_ACTIVE        = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  pos_t xpos_raw,
  input  pos_t ypos_raw,
  input  logic left_raw,
  input  logic vsync_in,
  output pos_t xpos,
  output pos_t ypos,
  output logic frame_tick,
  output logic left_held,
  output logic left_click,
  output pos_t click_x,
  output pos_t click_y
`ifdef MOUSE_RIGHT_BTN_EN
  ,
  input  logic right_raw,
  output logic right_held,
  output logic right_click
`endif
);

  pos_t pend_x;
  pos_t pend_y;
  logic vs_q1;
  logic vs_q2;
  logic vs_edge;
  logic left_fire;

  assign vs_edge = vs_q1 & ~vs_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_x     <= '0;
      pend_y     <= '0;
      vs_q1      <= 1'b0;
      vs_q2      <= 1'b0;
      xpos       <= '0;
      ypos       <= '0;
      frame_tick <= 1'b0;
    end else begin
      pend_x     <= clamp_pos(xpos_raw, H_ACTIVE);
      pend_y     <= clamp_pos(ypos_raw, V_ACTIVE);
      vs_q1      <= vsync_in;
      vs_q2      <= vs_q1;
      frame_tick <= vs_edge;
      if (vs_edge) begin
        xpos <= pend_x;
        ypos <= pend_y;
      end
    end
  end

  // Capture the position on screen when the click fires, ignoring a simultaneous frame update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      click_x <= '0;
      click_y <= '0;
    end else if (left_fire) begin
      click_x <= xpos;
      click_y <= ypos;
    end
  end

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (left_raw),
    .held        (left_held),
    .press_pulse (left_click),
    .press_fire  (left_fire)
  );

`ifdef MOUSE_RIGHT_BTN_EN
  logic right_fire;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk         (clk),
    .rst_n       (rst_n),
    .raw         (right_raw),
    .held        (right_held),
    .press_pulse (right_click),
    .press_fire  (right_fire)
  );
`endif

endmodule

// File: tb/tb_mouse_frame_latch.sv
// tb/tb_mouse_frame_latch.sv - self-checking bench for mouse_frame_latch with a sample-history reference model
module tb_mouse_frame_latch;
  import mouse_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pos_t xpos_raw = '0;
  pos_t ypos_raw = '0;
  logic left_raw = 1'b0;
  logic vsync_in = 1'b0;
  pos_t xpos, ypos, click_x, click_y;
  logic frame_tick, left_held, left_click;
`ifdef MOUSE_RIGHT_BTN_EN
  logic right_raw = 1'b0;
  logic right_held, right_click;
`endif

  always #5 clk = ~clk;

  mouse_frame_latch #(.H_ACTIVE(1024), .V_ACTIVE(768), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xpos_raw   (xpos_raw),
    .ypos_raw   (ypos_raw),
    .left_raw   (left_raw),
    .vsync_in   (vsync_in),
    .xpos       (xpos),
    .ypos       (ypos),
    .frame_tick (frame_tick),
    .left_held  (left_held),
    .left_click (left_click),
    .click_x    (click_x),
    .click_y    (click_y)
`ifdef MOUSE_RIGHT_BTN_EN
    ,
    .right_raw  (right_raw),
    .right_held (right_held),
    .right_click(right_click)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: what the screen shows, what is pending, and per-button sample history.
  int   m_x, m_y, m_px, m_py, m_cx, m_cy;
  logic m_tick;
  logic v_prev1, v_prev2;
  logic lq[$];
  logic m_lheld, m_lclick;
  int   m_lrun;
`ifdef MOUSE_RIGHT_BTN_EN
  logic rq[$];
  logic m_rheld, m_rclick;
  int   m_rrun;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampm(input int v, input int lim);
    return (v >= lim) ? lim - 1 : v;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_px = 0; m_py = 0; m_cx = 0; m_cy = 0;
    m_tick = 0; v_prev1 = 0; v_prev2 = 0;
    lq.delete(); m_lheld = 0; m_lclick = 0; m_lrun = 0;
`ifdef MOUSE_RIGHT_BTN_EN
    rq.delete(); m_rheld = 0; m_rclick = 0; m_rrun = 0;
`endif
  endtask

  // A button flips once its synchronized level has disagreed with the held level for D edges in a row.
  task automatic btn_model(input logic s, inout logic held, inout int run, output logic click);
    click = 0;
    if (s != held) run++;
    else run = 0;
    if (run == D) begin
      held = ~held;
      run = 0;
      click = held;
    end
  endtask

  task automatic model_edge();
    logic s;
    int old_x, old_y;
    old_x = m_x; old_y = m_y;
    m_tick = v_prev1 & ~v_prev2;
    if (m_tick) begin m_x = m_px; m_y = m_py; end
    m_px = clampm(int'(xpos_raw), 1024);
    m_py = clampm(int'(ypos_raw), 768);
    v_prev2 = v_prev1; v_prev1 = vsync_in;
    lq.push_back(left_raw);
    s = (lq.size() > 2) ? lq.pop_front() : 1'b0;
    btn_model(s, m_lheld, m_lrun, m_lclick);
    if (m_lclick) begin m_cx = old_x; m_cy = old_y; end
`ifdef MOUSE_RIGHT_BTN_EN
    rq.push_back(right_raw);
    s = (rq.size() > 2) ? rq.pop_front() : 1'b0;
    btn_model(s, m_rheld, m_rrun, m_rclick);
`endif
  endtask

  task automatic check_all();
    chk("xpos", xpos, m_x);
    chk("ypos", ypos, m_y);
    chk("frame_tick", frame_tick, m_tick);
    chk("left_held", left_held, m_lheld);
    chk("left_click", left_click, m_lclick);
    chk("click_x", click_x, m_cx);
    chk("click_y", click_y, m_cy);
`ifdef MOUSE_RIGHT_BTN_EN
    chk("right_held", right_held, m_rheld);
    chk("right_click", right_click, m_rclick);
`endif
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_all();
    end
  endtask

  int ticks, clicks, lrun_len, rrun_len;

  initial begin
    model_reset();
    #2;
    check_all();
    chk("reset_frame_tick", frame_tick, 0);
    @(negedge clk) rst_n = 1'b1;
    step(3);

    // Out-of-range position saturates and appears two edges after vsync rises.
    xpos_raw = 12'd1500; ypos_raw = 12'd900; vsync_in = 1'b1;
    step(1);
    chk("clamp_not_yet", xpos, 0);
    step(1);
    chk("clamp_x", xpos, 1023);
    chk("clamp_y", ypos, 767);
    chk("clamp_tick", frame_tick, 1);
    step(1);
    chk("tick_one_cycle", frame_tick, 0);
    vsync_in = 1'b0;

    // Intermediate raw values between frames are never shown.
    step(2);
    xpos_raw = 12'd100; step(2);
    xpos_raw = 12'd200; step(2);
    xpos_raw = 12'd300; step(2);
    chk("hold_between_frames", xpos, 1023);
    vsync_in = 1'b1;
    ticks = 0;
    repeat (8) begin step(1); ticks += int'(frame_tick); end
    chk("one_update_held_vsync", ticks, 1);
    chk("last_pending_used", xpos, 300);
    vsync_in = 1'b0;

    // A 2-cycle glitch is rejected; a long press gives one click after 2+D edges.
    left_raw = 1'b1; step(2); left_raw = 1'b0;
    clicks = 0;
    repeat (10) begin step(1); clicks += int'(left_click) + int'(left_held); end
    chk("glitch_no_click", clicks, 0);
    left_raw = 1'b1;
    clicks = 0;
    repeat (5) begin step(1); clicks += int'(left_click); end
    chk("held_not_before_6", left_held, 0);
    step(1); clicks += int'(left_click);
    chk("held_after_6", left_held, 1);
    repeat (2) begin step(1); clicks += int'(left_click); end
    chk("one_click", clicks, 1);

    // Asynchronous reset mid-run with a held button and a displayed position.
    #2;
    left_raw = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_xpos", xpos, 0);
    chk("async_rst_held", left_held, 0);
    check_all();
    @(negedge clk) rst_n = 1'b1;
    step(10);
    chk("idle_after_reset", left_held, 0);

    // Click on the same edge as a frame update reports the position shown before it.
    xpos_raw = 12'd10; vsync_in = 1'b1; step(3);
    vsync_in = 1'b0; step(2);
    chk("shown_10", xpos, 10);
    xpos_raw = 12'd50; step(2);
    left_raw = 1'b1; step(4);
    vsync_in = 1'b1; step(1);
    chk("no_click_yet", left_click, 0);
    step(1);
    chk("coincident_click", left_click, 1);
    chk("coincident_click_x", click_x, 10);
    chk("coincident_xpos", xpos, 50);
    step(2);
    chk("click_x_held", click_x, 10);
    left_raw = 1'b0; vsync_in = 1'b0;
    step(8);

`ifdef MOUSE_RIGHT_BTN_EN
    right_raw = 1'b1;
    clicks = 0; ticks = 0;
    repeat (8) begin step(1); clicks += int'(right_click); ticks += int'(left_click); end
    right_raw = 1'b0;
    repeat (8) begin step(1); clicks += int'(right_click); ticks += int'(left_click); end
    chk("right_one_click", clicks, 1);
    chk("right_no_left_click", ticks, 0);
    chk("right_click_x_same", click_x, 10);
`endif

    // Randomized traffic with boundary-biased coordinates and variable button run lengths.
    lrun_len = 0; rrun_len = 0;
    repeat (800) begin
      case ($urandom_range(0, 7))
        0: xpos_raw = 12'd1023;
        1: xpos_raw = 12'd1024;
        2: xpos_raw = 12'hFFF;
        default: xpos_raw = pos_t'($urandom_range(0, 2047));
      endcase
      case ($urandom_range(0, 7))
        0: ypos_raw = 12'd767;
        1: ypos_raw = 12'd768;
        2: ypos_raw = 12'hFFF;
        default: ypos_raw = pos_t'($urandom_range(0, 2047));
      endcase
      if ($urandom_range(0, 15) == 0) vsync_in = ~vsync_in;
      if (lrun_len == 0) begin
        left_raw = ~left_raw;
        lrun_len = $urandom_range(1, 9);
      end
      lrun_len--;
`ifdef MOUSE_RIGHT_BTN_EN
      if (rrun_len == 0) begin
        right_raw = ~right_raw;
        rrun_len = $urandom_range(1, 9);
      end
      rrun_len--;
`endif
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
